rv32i_uart_ctrl: RTL and testbench
==================================

// Module: rv32i_uart_ctrl
// PURPOSE
//  Memory-mapped controller between the RV32I data bus and the byte-level UART core.
//  Buffers CPU writes in a TX FIFO and paces them into the core one byte per frame via its valid/ready pair.
//  Captures each core rx_valid pulse into an RX FIFO, keeps sticky overflow flags and raises a level interrupt.
// PARAMETERS
//  FIFO_DEPTH  16  entries per FIFO; power of two, >=2
//  PTR_W       4   log2(FIFO_DEPTH)
// PORTS
//  clk            in   1   single clock
//  rst            in   1   synchronous, active-high reset
//  bus_sel        in   1   access strobe, one cycle per access
//  bus_we         in   1   1=write, 0=read (qualified by bus_sel)
//  bus_addr       in   2   word offset: 0=DATA, 1=STATUS, 2=CTRL
//  bus_wdata      in   32  write data
//  bus_rdata      out  32  read data, registered
//  irq            out  1   level interrupt
//  u_tx_data      out  8   byte to UART core
//  u_tx_valid     out  1   one-cycle launch pulse to core
//  u_tx_ready     in   1   core idle (high while idle, low while framing)
//  u_rx_data      in   8   received byte
//  u_rx_valid     in   1   one-cycle receive pulse
// BEHAVIOUR
//  Reset: bus_rdata=0, irq=0, u_tx_valid=0, u_tx_data=0; FIFOs empty; sticky flags, CTRL=0; TX FSM=IDLE.
//  Reset mid-operation: FIFOs flushed, FSM to IDLE; byte in flight in core not aborted; IDLE waits for u_tx_ready=1.
//  Bus: every access completes in the sel cycle; read data on bus_rdata the following cycle, held until next read.
//  DATA wr: push wdata[7:0] to TX FIFO; if full, drop byte, set TX_OVF.
//  DATA rd: return {24'b0, RX head}, pop; if RX empty return 0, no pop.
//  STATUS rd: [0]TX_EMPTY [1]TX_FULL [2]RX_EMPTY [3]RX_FULL [4]RX_OVF [5]TX_OVF [6]TX_BUSY(FSM!=IDLE), rest 0.
//  STATUS wr: write-1-to-clear bits [4],[5]; other bits ignored.
//  CTRL rw: [0]RX_IE, [1]TX_IE; others read 0.
//  irq = (RX_IE & !RX_EMPTY) | (TX_IE & TX_EMPTY & FSM==IDLE) | RX_OVF | TX_OVF; registered, 1-cycle lag.
//  RX: u_rx_valid pushes u_rx_data; if RX full and no pop this cycle, drop new byte, set RX_OVF, FIFO unchanged.
//  Simultaneous push+pop on full or empty FIFO: both take effect if legal (pop on empty ignored); count consistent.
//  Simultaneous STATUS W1C and new overflow event same cycle: set wins.
//  TX FSM (sequences the core; never launches while core busy):
//   IDLE:      if !TX_EMPTY & u_tx_ready -> u_tx_valid=1 one cycle, u_tx_data=head, pop; -> WAIT_ACK
//   WAIT_ACK:  wait u_tx_ready==0 (core accepted) -> WAIT_DONE
//   WAIT_DONE: wait u_tx_ready==1 -> IDLE (next launch no earlier than following cycle)
//  u_tx_data holds launched byte until next launch. CPU write to empty FIFO: u_tx_valid no later than 2 cycles after.
//  FIFO count width PTR_W+1; pointers wrap modulo FIFO_DEPTH.
// STRUCTURE
//  Package rv32i_uart_pkg: register offsets (DATA/STATUS/CTRL), STATUS/CTRL bit indices, TX FSM state encoding.
//  Sub-module rv32i_sync_fifo (WIDTH, DEPTH; push/pop/full/empty/count, pop-on-empty and push-on-full ignored),
//  instantiated twice (8-bit TX, 8-bit RX). FSM, register decode, flags, irq in this module.
//  Pairs with the UART core; bench instantiates both with small BAUD_DIV (e.g. 4) plus a core-only model mode.
// TESTING
//  Write DATA=0x55, core idle -> u_tx_valid single pulse with u_tx_data=0x55 within 2 cycles; TX_BUSY=1 until ready returns.
//  Write 0x11,0x22,0x33 back-to-back -> exactly 3 launches in order, each after u_tx_ready 0->1; loopback RX reads same.
//  Write 17 bytes while core held busy -> 16 queued, STATUS[5]=1; W1C 0x20 clears it; 16 bytes transmitted.
//  Pulse u_rx_valid 17x (0x00..0x10) with no reads -> RX_FULL, RX_OVF=1; reads return 0x00..0x0F then empty reads 0.
//  RX full + DATA read and u_rx_valid same cycle -> no overflow, count stays 16, new byte last in order.
//  RX_IE=1, one byte received -> irq=1; read DATA -> irq=0 one cycle later. Assert rst mid-frame -> all outputs 0, FIFOs empty.

Source files
------------

// File: rtl/rv32i_uart_pkg.sv
// Shared definitions for the RV32I UART controller: register map, bit positions, TX sequencer states.
package rv32i_uart_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    localparam int unsigned ST_TX_EMPTY = 0;
    localparam int unsigned ST_TX_FULL  = 1;
    localparam int unsigned ST_RX_EMPTY = 2;
    localparam int unsigned ST_RX_FULL  = 3;
    localparam int unsigned ST_RX_OVF   = 4;
    localparam int unsigned ST_TX_OVF   = 5;
    localparam int unsigned ST_TX_BUSY  = 6;
    localparam int unsigned ST_W        = 7;

    localparam int unsigned CTRL_RX_IE = 0;
    localparam int unsigned CTRL_TX_IE = 1;

    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_WAIT_ACK  = 2'd1,
        TX_WAIT_DONE = 2'd2
    } tx_state_e;

endpackage

// File: rtl/rv32i_sync_fifo.sv
// Single-clock FIFO; pop on empty is ignored, push on full is accepted only when a pop frees a slot.
module rv32i_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PTR_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/rv32i_uart_ctrl.sv
// Memory-mapped UART controller: TX/RX byte FIFOs, sticky overflow flags, level irq,
// and a sequencer that launches one byte per core frame over the valid/ready pair.
module rv32i_uart_ctrl
    import rv32i_uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned PTR_W      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_sel,
    input  logic        bus_we,
    input  logic [1:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        irq,
    output logic [7:0]  u_tx_data,
    output logic        u_tx_valid,
    input  logic        u_tx_ready,
    input  logic [7:0]  u_rx_data,
    input  logic        u_rx_valid
);

    logic            wr_en, rd_en;
    logic            tx_push, tx_pop, rx_pop;
    logic            tx_full, tx_empty, rx_full, rx_empty;
    logic [7:0]      tx_head, rx_head;
    logic [PTR_W:0]  tx_count, rx_count;
    logic            tx_ovf_q, rx_ovf_q;
    logic            tx_ovf_evt, rx_ovf_evt;
    logic            stat_wr;
    logic [1:0]      ctrl_q;
    logic [ST_W-1:0] status;
    logic [31:0]     rdata_d;
    logic            irq_d;
    logic            tx_launch;
    tx_state_e       tx_state_q, tx_state_d;
    logic            unused_bits;

    assign wr_en   = bus_sel & bus_we;
    assign rd_en   = bus_sel & ~bus_we;
    assign stat_wr = wr_en & (bus_addr == ADDR_STATUS);
    assign tx_push = wr_en & (bus_addr == ADDR_DATA);
    assign rx_pop  = rd_en & (bus_addr == ADDR_DATA) & ~rx_empty;
    assign tx_pop  = tx_launch;

    // A drop only happens when no pop frees a slot in the same cycle
    assign tx_ovf_evt = tx_push & tx_full & ~tx_pop;
    assign rx_ovf_evt = u_rx_valid & rx_full & ~rx_pop;

    assign unused_bits = ^{tx_count, rx_count, bus_wdata[31:8]};

    rv32i_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH), .PTR_W(PTR_W)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (tx_pop),
        .wdata (bus_wdata[7:0]),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    rv32i_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH), .PTR_W(PTR_W)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (u_rx_valid),
        .pop   (rx_pop),
        .wdata (u_rx_data),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    always_comb begin
        tx_state_d = tx_state_q;
        tx_launch  = 1'b0;
        unique case (tx_state_q)
            TX_IDLE: begin
                if (!tx_empty && u_tx_ready) begin
                    tx_launch  = 1'b1;
                    tx_state_d = TX_WAIT_ACK;
                end
            end
            TX_WAIT_ACK:  if (!u_tx_ready) tx_state_d = TX_WAIT_DONE;
            TX_WAIT_DONE: if (u_tx_ready)  tx_state_d = TX_IDLE;
            default:      tx_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        status              = '0;
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_TX_FULL]  = tx_full;
        status[ST_RX_EMPTY] = rx_empty;
        status[ST_RX_FULL]  = rx_full;
        status[ST_RX_OVF]   = rx_ovf_q;
        status[ST_TX_OVF]   = tx_ovf_q;
        status[ST_TX_BUSY]  = (tx_state_q != TX_IDLE);
    end

    always_comb begin
        rdata_d = '0;
        unique case (bus_addr)
            ADDR_DATA:   if (!rx_empty) rdata_d[7:0] = rx_head;
            ADDR_STATUS: rdata_d[ST_W-1:0] = status;
            ADDR_CTRL:   rdata_d[1:0] = ctrl_q;
            default:     ;
        endcase
    end

    assign irq_d = (ctrl_q[CTRL_RX_IE] & ~rx_empty)
                 | (ctrl_q[CTRL_TX_IE] & tx_empty & (tx_state_q == TX_IDLE))
                 | rx_ovf_q | tx_ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            u_tx_valid <= 1'b0;
            u_tx_data  <= '0;
            bus_rdata  <= '0;
            irq        <= 1'b0;
            ctrl_q     <= '0;
            tx_ovf_q   <= 1'b0;
            rx_ovf_q   <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            u_tx_valid <= tx_launch;
            if (tx_launch) u_tx_data <= tx_head;
            if (rd_en) bus_rdata <= rdata_d;
            irq <= irq_d;
            if (wr_en && bus_addr == ADDR_CTRL) ctrl_q <= bus_wdata[1:0];
            // A new overflow in the same cycle as its clear leaves the flag set
            if (tx_ovf_evt)                          tx_ovf_q <= 1'b1;
            else if (stat_wr && bus_wdata[ST_TX_OVF]) tx_ovf_q <= 1'b0;
            if (rx_ovf_evt)                          rx_ovf_q <= 1'b1;
            else if (stat_wr && bus_wdata[ST_RX_OVF]) rx_ovf_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rv32i_uart_ctrl.sv
// Scoreboard bench for rv32i_uart_ctrl with a behavioural UART core (optional loopback) and queue-based reference model.
module tb_rv32i_uart_ctrl;

    localparam int unsigned DEPTH    = 16;
    localparam int unsigned BAUD_DIV = 4;
    localparam int          FRAME    = 10 * BAUD_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bus_sel = 1'b0;
    logic        bus_we = 1'b0;
    logic [1:0]  bus_addr = 2'd0;
    logic [31:0] bus_wdata = 32'd0;
    logic [31:0] bus_rdata;
    logic        irq;
    logic [7:0]  u_tx_data;
    logic        u_tx_valid;
    logic        u_tx_ready;
    logic [7:0]  u_rx_data;
    logic        u_rx_valid;

    always #5 clk = ~clk;

    rv32i_uart_ctrl #(.FIFO_DEPTH(16), .PTR_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus_sel    (bus_sel),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .irq        (irq),
        .u_tx_data  (u_tx_data),
        .u_tx_valid (u_tx_valid),
        .u_tx_ready (u_tx_ready),
        .u_rx_data  (u_rx_data),
        .u_rx_valid (u_rx_valid)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain queues and flags
    logic [7:0]  tx_exp[$];
    logic [7:0]  m_rx[$];
    logic [31:0] rd_exp[$];
    logic [1:0]  rd_addr_q[$];
    bit          m_rx_ovf = 0;
    bit          m_tx_ovf = 0;
    logic [1:0]  m_ctrl = 2'd0;

    function automatic void m_rx_push(input logic [7:0] b);
        if (m_rx.size() >= DEPTH) m_rx_ovf = 1;
        else m_rx.push_back(b);
    endfunction

    function automatic logic [31:0] m_rx_read();
        if (m_rx.size() == 0) return 32'd0;
        return {24'd0, m_rx.pop_front()};
    endfunction

    function automatic logic [31:0] exp_status(input bit busy);
        logic [31:0] s;
        s = 32'd0;
        s[0] = (tx_exp.size() == 0);
        s[1] = (tx_exp.size() == DEPTH);
        s[2] = (m_rx.size() == 0);
        s[3] = (m_rx.size() == DEPTH);
        s[4] = m_rx_ovf;
        s[5] = m_tx_ovf;
        s[6] = busy;
        return s;
    endfunction

    // Behavioural UART core: busy for one frame after accepting a byte, optional loopback
    logic       hold_busy = 1'b0;
    logic       loopback = 1'b0;
    int         busy_cnt = 0;
    logic [7:0] core_byte = 8'd0;
    logic       core_rx_valid = 1'b0;
    logic [7:0] core_rx_data = 8'd0;
    logic       tb_rx_valid = 1'b0;
    logic [7:0] tb_rx_data = 8'd0;

    assign u_tx_ready = !hold_busy && (busy_cnt == 0);
    assign u_rx_valid = tb_rx_valid | core_rx_valid;
    assign u_rx_data  = core_rx_valid ? core_rx_data : tb_rx_data;

    always @(posedge clk) begin
        core_rx_valid <= 1'b0;
        if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1 && loopback) begin
                core_rx_valid <= 1'b1;
                core_rx_data  <= core_byte;
                m_rx_push(core_byte);
            end
        end else if (u_tx_valid && u_tx_ready) begin
            busy_cnt  <= FRAME;
            core_byte <= u_tx_data;
        end
    end

    // Monitor: compares every read response and every launch against the queues
    logic        rd_seen = 1'b0;
    logic [31:0] mon_e;
    logic [1:0]  mon_a;
    logic [7:0]  mon_b;

    always @(posedge clk) rd_seen <= bus_sel && !bus_we && !rst;

    always @(negedge clk) begin
        if (rd_seen) begin
            if (rd_exp.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL read_unexpected: got 0x%0h, expected no read", bus_rdata);
            end else begin
                mon_e = rd_exp.pop_front();
                mon_a = rd_addr_q.pop_front();
                check($sformatf("read_addr%0d", mon_a), bus_rdata, mon_e);
            end
        end
        if (u_tx_valid) begin
            if (tx_exp.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL tx_unexpected: got launch of 0x%0h, expected none", u_tx_data);
            end else begin
                mon_b = tx_exp.pop_front();
                check("tx_byte", {24'd0, u_tx_data}, {24'd0, mon_b});
            end
            check("tx_ready_at_launch", {31'd0, u_tx_ready}, 32'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        case (a)
            2'd0: if (tx_exp.size() >= DEPTH) m_tx_ovf = 1; else tx_exp.push_back(d[7:0]);
            2'd1: begin
                if (d[4]) m_rx_ovf = 0;
                if (d[5]) m_tx_ovf = 0;
            end
            2'd2: m_ctrl = d[1:0];
            default: ;
        endcase
        bus_sel = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
        tick();
        bus_sel = 1'b0; bus_we = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a, input bit busy);
        logic [31:0] e;
        case (a)
            2'd0:    e = m_rx_read();
            2'd1:    e = exp_status(busy);
            2'd2:    e = {30'd0, m_ctrl};
            default: e = 32'd0;
        endcase
        rd_exp.push_back(e);
        rd_addr_q.push_back(a);
        bus_sel = 1'b1; bus_we = 1'b0; bus_addr = a;
        tick();
        bus_sel = 1'b0;
    endtask

    task automatic rx_pulse(input logic [7:0] b, input bit with_read);
        if (with_read) begin
            rd_exp.push_back(m_rx_read());
            rd_addr_q.push_back(2'd0);
            bus_sel = 1'b1; bus_we = 1'b0; bus_addr = 2'd0;
        end
        m_rx_push(b);
        tb_rx_valid = 1'b1; tb_rx_data = b;
        tick();
        tb_rx_valid = 1'b0; bus_sel = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((tx_exp.size() != 0 || !u_tx_ready) && n < 3000) begin
            tick();
            n++;
        end
        n_cmp++;
        if (n >= 3000) begin
            n_err++;
            $display("FAIL %s: timeout, %0d bytes still pending, expected drained", name, tx_exp.size());
        end
        tick();
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int op;

        // Reset state
        tick(); tick(); tick();
        rst = 1'b0;
        check("reset_rdata", bus_rdata, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        check("reset_tx_valid", {31'd0, u_tx_valid}, 32'd0);
        check("reset_tx_data", {24'd0, u_tx_data}, 32'd0);
        bus_rd(2'd1, 0);
        bus_rd(2'd2, 0);
        bus_rd(2'd0, 0);

        // Single byte, launch latency and busy flag
        bus_wr(2'd0, 32'h55);
        found = 0;
        for (int k = 0; k < 2 && !found; k++) begin
            @(negedge clk);
            if (u_tx_valid) found = 1;
        end
        check("launch_within_2", {31'd0, found}, 32'd1);
        tick(); tick();
        bus_rd(2'd1, 1);
        wait_idle("single_byte");
        bus_rd(2'd1, 0);

        // Back-to-back writes with loopback
        loopback = 1'b1;
        bus_wr(2'd0, 32'h11);
        bus_wr(2'd0, 32'h22);
        bus_wr(2'd0, 32'h33);
        wait_idle("loopback");
        loopback = 1'b0;
        for (int k = 0; k < 4; k++) bus_rd(2'd0, 0);

        // TX overflow while the core is held busy
        hold_busy = 1'b1;
        for (int k = 0; k < 17; k++) bus_wr(2'd0, $urandom);
        bus_rd(2'd1, 0);
        tick();
        check("irq_tx_ovf", {31'd0, irq}, 32'd1);
        bus_wr(2'd1, 32'h20);
        bus_rd(2'd1, 0);
        tick();
        check("irq_tx_ovf_cleared", {31'd0, irq}, 32'd0);
        hold_busy = 1'b0;
        wait_idle("tx_drain16");
        bus_rd(2'd1, 0);

        // RX overflow: 17 pulses, no reads
        for (int k = 0; k < 17; k++) rx_pulse(8'(k), 0);
        bus_rd(2'd1, 0);
        check("irq_rx_ovf", {31'd0, irq}, 32'd1);
        for (int k = 0; k < 17; k++) bus_rd(2'd0, 0);
        bus_wr(2'd1, 32'h10);
        bus_rd(2'd1, 0);

        // RX full with simultaneous read and receive
        for (int k = 0; k < 16; k++) rx_pulse(8'($urandom), 0);
        bus_rd(2'd1, 0);
        rx_pulse(8'hEE, 1);
        bus_rd(2'd1, 0);
        for (int k = 0; k < 17; k++) bus_rd(2'd0, 0);

        // Interrupt enables and one-cycle irq lag
        bus_wr(2'd2, 32'h1);
        rx_pulse(8'hA5, 0);
        tick();
        check("irq_rx_ie", {31'd0, irq}, 32'd1);
        bus_rd(2'd0, 0);
        check("irq_lag_after_pop", {31'd0, irq}, 32'd1);
        tick();
        check("irq_clear_after_pop", {31'd0, irq}, 32'd0);
        bus_wr(2'd2, 32'h2);
        tick();
        check("irq_tx_ie", {31'd0, irq}, 32'd1);
        bus_rd(2'd2, 0);
        bus_wr(2'd2, 32'h0);
        tick();
        check("irq_off", {31'd0, irq}, 32'd0);

        // Randomized mix of traffic
        for (int k = 0; k < 300; k++) begin
            op = int'($urandom_range(0, 4));
            case (op)
                0: if (tx_exp.size() < 8) bus_wr(2'd0, $urandom); else tick();
                1: rx_pulse(8'($urandom), bit'($urandom_range(0, 1)));
                2: bus_rd(2'd0, 0);
                3: bus_rd(2'd2, 0);
                default: tick();
            endcase
        end
        wait_idle("random");
        bus_rd(2'd1, 0);
        bus_wr(2'd1, 32'h30);
        for (int k = 0; k < 17; k++) bus_rd(2'd0, 0);
        bus_rd(2'd1, 0);

        // Reset during a frame
        bus_wr(2'd0, 32'hC3);
        bus_wr(2'd0, 32'h3C);
        found = 0;
        for (int k = 0; k < 6 && !found; k++) begin
            @(negedge clk);
            if (u_tx_valid) found = 1;
        end
        check("launch_before_reset", {31'd0, found}, 32'd1);
        tick(); tick(); tick();
        rst = 1'b1;
        tx_exp.delete();
        m_rx.delete();
        m_rx_ovf = 0; m_tx_ovf = 0; m_ctrl = 2'd0;
        tick();
        check("midreset_rdata", bus_rdata, 32'd0);
        check("midreset_irq", {31'd0, irq}, 32'd0);
        check("midreset_tx_valid", {31'd0, u_tx_valid}, 32'd0);
        check("midreset_tx_data", {24'd0, u_tx_data}, 32'd0);
        tick();
        rst = 1'b0;
        bus_rd(2'd1, 0);
        wait_idle("post_reset_core");
        bus_wr(2'd0, 32'h5A);
        wait_idle("post_reset_tx");
        bus_rd(2'd1, 0);

        tick(); tick();
        check("tx_queue_drained", 32'(tx_exp.size()), 32'd0);
        check("rd_queue_drained", 32'(rd_exp.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
